// File: rtl/mips_pkg.sv
// Constants and types shared by the fetch stage, IF/ID register and control unit.
// Holds the bubble encoding, reset PC, PC increment and fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'hE000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HOLD   = 2'd2,
    FS_SQUASH = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold register for an instruction and its fetch address.
// A clear wins over a simultaneous load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] addr_in,
  output logic [31:0] instr_out,
  output logic [31:0] addr_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      addr_d  = addr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0;
      addr_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign addr_out  = addr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous-read imem,
// and feeds IF/ID while honouring stalls and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        Branch_Control,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out
);

  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_addr_q, rsp_addr_d;
  logic         rsp_valid_q, rsp_valid_d;

  logic         skid_load, skid_clear;
  logic [31:0]  skid_instr_q, skid_addr_q;
  logic         skid_valid_q;
  logic         redirect;

  assign redirect  = Branch_Control & branch_taken;
  assign imem_addr = pc_q;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .instr_in  (imem_rdata),
    .addr_in   (rsp_addr_q),
    .instr_out (skid_instr_q),
    .addr_out  (skid_addr_q),
    .valid_out (skid_valid_q)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    rsp_addr_d      = rsp_addr_q;
    rsp_valid_d     = rsp_valid_q;
    skid_load       = 1'b0;
    skid_clear      = 1'b0;
    Instruction_out = NOP_INSTR;
    PC_out          = pc_q + PC_STEP;

    case (state_q)
      FS_RUN: begin
        if (rsp_valid_q) Instruction_out = imem_rdata;
        PC_out = rsp_addr_q + PC_STEP;
      end
      FS_HOLD: begin
        // Right after a squash the skid is still empty; the target word sits on imem_rdata.
        if (skid_valid_q) begin
          Instruction_out = skid_instr_q;
          PC_out          = skid_addr_q + PC_STEP;
        end else if (rsp_valid_q) begin
          Instruction_out = imem_rdata;
          PC_out          = rsp_addr_q + PC_STEP;
        end
      end
      default: ;
    endcase

    if (redirect && state_q != FS_BOOT) begin
      pc_d        = word_align(branch_target);
      rsp_valid_d = 1'b0;
      skid_clear  = 1'b1;
      state_d     = FS_SQUASH;
    end else begin
      case (state_q)
        FS_BOOT: begin
          pc_d        = pc_q + PC_STEP;
          rsp_addr_d  = pc_q;
          rsp_valid_d = 1'b1;
          state_d     = FS_RUN;
        end
        FS_SQUASH: begin
          rsp_addr_d  = pc_q;
          rsp_valid_d = 1'b1;
          if (enable) begin
            pc_d    = pc_q + PC_STEP;
            state_d = FS_RUN;
          end else begin
            state_d = FS_HOLD;
          end
        end
        FS_RUN: begin
          if (enable) begin
            pc_d       = pc_q + PC_STEP;
            rsp_addr_d = pc_q;
          end else begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (enable) begin
            skid_clear  = 1'b1;
            rsp_addr_d  = pc_q;
            rsp_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = FS_RUN;
          end else if (!skid_valid_q && rsp_valid_q) begin
            skid_load = 1'b1;
          end
        end
        default: state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_BOOT;
      pc_q        <= RESET_PC;
      rsp_addr_q  <= RESET_PC;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_if_fetch_unit;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, bc, bt;
  logic [31:0] target;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;

  logic        reset_w;
  logic [31:0] imem_addr_w, imem_rdata_w, instr_out_w, pc_out_w;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;
  bit   wrap_done = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit u_dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .Branch_Control  (bc),
    .branch_taken    (bt),
    .branch_target   (target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .Instruction_out (instr_out),
    .PC_out          (pc_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk             (clk),
    .reset           (reset_w),
    .enable          (1'b1),
    .Branch_Control  (1'b0),
    .branch_taken    (1'b0),
    .branch_target   (32'h0),
    .imem_addr       (imem_addr_w),
    .imem_rdata      (imem_rdata_w),
    .Instruction_out (instr_out_w),
    .PC_out          (pc_out_w)
  );

  // Synchronous-read memory models: mem[a] = 0x1000_0000 + a.
  always @(posedge clk) begin
    imem_rdata   <= 32'h1000_0000 + imem_addr;
    imem_rdata_w <= 32'h1000_0000 + imem_addr_w;
  end

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("instr", e.cyc, instr_out, e.instr);
      chk("pc_out", e.cyc, pc_out, e.pc);
      chk("imem_addr", e.cyc, imem_addr, e.addr);
      $display("main cycle %0d: instr=%h pc_out=%h imem_addr=%h", e.cyc, instr_out, pc_out, imem_addr);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("wrap instr", e.cyc, instr_out_w, e.instr);
      chk("wrap pc_out", e.cyc, pc_out_w, e.pc);
      chk("wrap imem_addr", e.cyc, imem_addr_w, e.addr);
      $display("wrap cycle %0d: instr=%h pc_out=%h imem_addr=%h", e.cyc, instr_out_w, pc_out_w, imem_addr_w);
    end
  end

  // Push the expectation for the current cycle, then drive inputs for the next edge.
  task automatic cyc(input logic r, input logic en, input logic b_c, input logic b_t,
                     input logic [31:0] tgt, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ea);
    exp_t e;
    cyc_no++;
    e.cyc = cyc_no; e.instr = ei; e.pc = ep; e.addr = ea;
    q0.push_back(e);
    reset = r; enable = en; bc = b_c; bt = b_t; target = tgt;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    reset_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.cyc = i + 1;
      case (i)
        0: begin e.instr = 32'hE000_0000; e.pc = 32'hFFFF_FFFC; e.addr = 32'hFFFF_FFF8; end
        1: begin e.instr = 32'h0FFF_FFF8; e.pc = 32'hFFFF_FFFC; e.addr = 32'hFFFF_FFFC; end
        2: begin e.instr = 32'h0FFF_FFFC; e.pc = 32'h0000_0000; e.addr = 32'h0000_0000; end
        default: begin e.instr = 32'h1000_0000; e.pc = 32'h0000_0004; e.addr = 32'h0000_0004; end
      endcase
      q1.push_back(e);
      @(posedge clk); #1;
    end
    wrap_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; bc = 1'b0; bt = 1'b0; target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    //   rst  en   bc   bt   target        instr_out     pc_out        imem_addr
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h004, 32'h000); // reset state
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0000, 32'h004, 32'h004);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0004, 32'h008, 32'h008); // stall begins
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0004, 32'h008, 32'h008);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0004, 32'h008, 32'h008);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0004, 32'h008, 32'h008);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0008, 32'h00C, 32'h00C);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'h1000_000C, 32'h010, 32'h010); // redirect
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h044, 32'h040);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h80,  32'h1000_0040, 32'h044, 32'h044); // taken w/o control
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h43,  32'h1000_0044, 32'h048, 32'h048); // redirect + stall
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h044, 32'h040);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0040, 32'h044, 32'h040);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0040, 32'h044, 32'h040);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0040, 32'h044, 32'h044);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0044, 32'h048, 32'h048);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0044, 32'h048, 32'h048); // reset in HOLD
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h004, 32'h000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0000, 32'h004, 32'h004);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h1000_0004, 32'h008, 32'h008);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hE000_0000, 32'h104, 32'h100); // redirect in SQUASH
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h204, 32'h200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1000_0200, 32'h204, 32'h204);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h1000_0200, 32'h204, 32'h204); // redirect in HOLD
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hE000_0000, 32'h304, 32'h300);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1000_0300, 32'h304, 32'h304);
    for (int i = 0; i < 20 && !wrap_done; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("main queue drained", cyc_no, q0.size(), 32'd0);
    chk("wrap queue drained", cyc_no, q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC, drives a synchronous-read instruction memory with 1-cycle read latency, and presents Instruction_out/PC_out (PC+4) to IF/ID.
- Honours hazard stalls through `enable` and branch redirects through `Branch_Control`/`branch_taken`, without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- NOP_INSTR, 32'hE0000000, bubble encoding (opcode 111000, control-unit default).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- enable  input  1  1 = advance, 0 = hazard stall; same signal that feeds IF/ID enable.
- Branch_Control  input  1  ID stage holds a branch or jump.
- branch_taken  input  1  ID-stage branch/jump resolved taken; effective only with Branch_Control=1.
- branch_target  input  32  redirect address, word-aligned.
- imem_addr  output  32  fetch address to instruction memory.
- imem_rdata  input  32  memory data for the address presented one cycle earlier.
- Instruction_out  output  32  instruction to IF/ID Instruction_in.
- PC_out  output  32  fetch address + 4 to IF/ID PC_in.

Behaviour:
- Priority each posedge: reset > redirect (Branch_Control & branch_taken) > stall (enable=0) > advance.
- Internal state:
  - pc_q: address issued this cycle; imem_addr = pc_q, combinational.
  - rsp_addr_q: address whose data is on imem_rdata this cycle.
  - rsp_valid_q: imem_rdata is a live, unsquashed response.
  - skid_instr_q / skid_addr_q / skid_valid_q: one-entry hold buffer.
- FSM states: BOOT, RUN, HOLD, SQUASH.
- Reset:
  - pc_q = RESET_PC; rsp_valid_q = 0; skid_valid_q = 0; state = BOOT.
  - Outputs in the first cycle after reset: Instruction_out = NOP_INSTR, PC_out = RESET_PC + 4, imem_addr = RESET_PC.
- BOOT: first address is in flight; output NOP. Next posedge: pc_q += 4, rsp_valid_q = 1, go to RUN (BOOT ignores enable).
- RUN:
  - Output imem_rdata, with PC_out = rsp_addr_q + 4.
  - enable=1: pc_q += 4; rsp_addr_q = pc_q.
  - enable=0: capture imem_rdata/rsp_addr_q into skid; hold pc_q; go to HOLD.
- HOLD:
  - Output skid_instr_q, with PC_out = skid_addr_q + 4. imem_addr stays pc_q, which is re-issued every cycle.
  - enable=1: skid_valid_q clears; rsp_addr_q = pc_q; pc_q += 4; go to RUN.
  - Steady stall holds every output constant.
- Redirect in any state except BOOT:
  - pc_q = branch_target; rsp_valid_q = 0; skid_valid_q = 0; go to SQUASH.
  - Redirect wins over a simultaneous stall.
- SQUASH:
  - Output NOP_INSTR, with PC_out = branch_target + 4 as latched in pc_q.
  - Response to the target is in flight. Next posedge behaves like BOOT: advance if enable=1, else go to HOLD with the skid loaded from imem_rdata.
- Redirect arriving in SQUASH reloads the new target and stays in SQUASH.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0. Bits [1:0] of branch_target are forced to 0.
- Reset mid-stall or mid-squash discards the skid and any in-flight response; there is no partial state.
- No combinational path from enable or branch inputs to imem_addr. Decisions take effect at the next posedge only.

Decomposition:
- Shared package `mips_pkg`: NOP_INSTR, RESET_PC, the fetch-state enum encoding, and PC_STEP = 4; the same constants feed IF/ID and the control unit.
- One sub-module, `fetch_skid_buf`: 1-entry instruction/address hold register with load/clear/valid.

Test Plan:
- Reset release, enable=1, memory returns mem[a] = 32'h1000_0000 + a:
  - Cycle 1: Instruction_out = E0000000, PC_out = 4.
  - Then 10000000/4, 10000004/8, 10000008/C on consecutive cycles.
- Stall enable=0 for 3 cycles while 10000004 is presented:
  - Instruction_out holds 10000004 and PC_out holds 8 throughout; imem_addr is constant.
  - After release, next output is 10000008; no skip, no duplicate.
- Branch_Control=1, branch_taken=1, branch_target=32'h40 during RUN:
  - Next cycle: NOP, imem_addr = 40.
  - Following cycle: 10000040 with PC_out = 44.
- Redirect and enable=0 in the same cycle:
  - Redirect wins: NOP, then hold on 10000040 until enable returns.
- Branch_Control=0 with branch_taken=1 → no redirect; sequence continues.
- reset asserted while in HOLD → next cycle is BOOT outputs (NOP, PC_out = 4); skid is empty.
- RESET_PC = 32'hFFFFFFF8 → fetch addresses FFFFFFF8, FFFFFFFC, 0.
